// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and width helper for the input scan debouncer
package debounce_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int DEFAULT_N_INPUTS     = 4;
    localparam int DEFAULT_TICK_DIV     = 27000;
    localparam int DEFAULT_STABLE_TICKS = 10;

    // Counters only ever reach STABLE_TICKS-1; the extra headroom keeps STABLE_TICKS=1 legal.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/input_scan_debouncer_if.sv
// rtl/input_scan_debouncer_if.sv - switch-level bus between pad logic and the debouncer
interface input_scan_debouncer_if #(
    parameter int N_INPUTS = 4
);
    logic [N_INPUTS-1:0] noisy_in;
    logic [N_INPUTS-1:0] enable_in;
    logic [N_INPUTS-1:0] clean_out;
    logic [N_INPUTS-1:0] rise_out;
    logic [N_INPUTS-1:0] fall_out;
    logic                scan_busy_out;

    modport master (
        output noisy_in,
        output enable_in,
        input  clean_out,
        input  rise_out,
        input  fall_out,
        input  scan_busy_out
    );

    modport slave (
        input  noisy_in,
        input  enable_in,
        output clean_out,
        output rise_out,
        output fall_out,
        output scan_busy_out
    );
endinterface

// File: rtl/debounce_tick_gen.sv
// rtl/debounce_tick_gen.sv - free-running prescaler emitting one scan tick every TICK_DIV cycles
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clock_in,
    input  logic reset_n_in,
    output logic tick_out
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick_out = (count_q == LAST);

endmodule

// File: rtl/input_scan_debouncer.sv
// rtl/input_scan_debouncer.sv - round-robin debouncer for switch inputs with a shared prescaler
module input_scan_debouncer
    import debounce_pkg::*;
#(
    parameter int N_INPUTS     = DEFAULT_N_INPUTS,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input_scan_debouncer_if.slave   bus
);
    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    if (TICK_DIV < N_INPUTS + 2 || STABLE_TICKS < 1) begin : g_param_check
        $error("input_scan_debouncer: TICK_DIV must be >= N_INPUTS+2 and STABLE_TICKS >= 1");
    end

    logic [N_INPUTS-1:0] sync_meta_q;
    logic [N_INPUTS-1:0] sync_q;
    logic [N_INPUTS-1:0] clean_q;
    logic [N_INPUTS-1:0] rise_q;
    logic [N_INPUTS-1:0] fall_q;
    logic [CNT_W-1:0]    cnt_q [N_INPUTS];

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tick;
    logic                scan_active;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .tick_out   (tick)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= bus.noisy_in;
            sync_q      <= sync_meta_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A tick landing while SCAN is still running is simply ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan_active = (state_q == SCAN);

    // Only the channel in the current scan slot is touched, so pulses stay one-hot.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            if (scan_active) begin
                if (!bus.enable_in[idx_q] || (sync_q[idx_q] == clean_q[idx_q])) begin
                    cnt_q[idx_q] <= '0;
                end else if (cnt_q[idx_q] == CNT_LAST) begin
                    cnt_q[idx_q]   <= '0;
                    clean_q[idx_q] <= sync_q[idx_q];
                    rise_q[idx_q]  <= sync_q[idx_q];
                    fall_q[idx_q]  <= ~sync_q[idx_q];
                end else begin
                    cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
                end
            end
        end
    end

    assign bus.clean_out     = clean_q;
    assign bus.rise_out      = rise_q;
    assign bus.fall_out      = fall_q;
    assign bus.scan_busy_out = scan_active;

endmodule

// File: tb/tb_input_scan_debouncer.sv
// tb/tb_input_scan_debouncer.sv - scoreboard bench for input_scan_debouncer (N=4, DIV=8, STABLE=3)
module tb_input_scan_debouncer;

    logic clock_in;
    logic reset_n_in;

    input_scan_debouncer_if #(.N_INPUTS(4)) bus ();

    input_scan_debouncer #(
        .N_INPUTS     (4),
        .TICK_DIV     (8),
        .STABLE_TICKS (3)
    ) dut (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected entry layout: {rise, fall, clean} at the pulse cycle.
    task automatic expect_pulse(input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] clean);
        exp_q.push_back({rise, fall, clean});
    endtask

    task automatic wait_busy(input logic val, input int budget);
        int used = 0;
        while (bus.scan_busy_out !== val && used < budget) begin
            @(negedge clock_in);
            used++;
        end
        if (used >= budget) check("busy_timeout", {31'd0, bus.scan_busy_out}, {31'd0, val});
    endtask

    task automatic align_after_scan();
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 20);
    endtask

    task automatic wait_clean(input logic [3:0] val, input int budget, output int used);
        used = 0;
        while (bus.clean_out !== val && used < budget) begin
            @(negedge clock_in);
            used++;
        end
    endtask

    always @(negedge clock_in) begin
        if (reset_n_in === 1'b1 && (bus.rise_out !== 4'd0 || bus.fall_out !== 4'd0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {20'd0, bus.rise_out, bus.fall_out, bus.clean_out}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse", {20'd0, bus.rise_out, bus.fall_out, bus.clean_out}, {20'd0, mon_e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int n;

        // Reset held with all inputs high
        reset_n_in    = 1'b0;
        bus.noisy_in  = 4'hF;
        bus.enable_in = 4'hF;
        repeat (3) @(negedge clock_in);
        check("reset_clean", {28'd0, bus.clean_out}, 32'd0);
        check("reset_rise",  {28'd0, bus.rise_out},  32'd0);
        check("reset_fall",  {28'd0, bus.fall_out},  32'd0);
        check("reset_busy",  {31'd0, bus.scan_busy_out}, 32'd0);
        repeat (20) @(negedge clock_in);
        check("reset_hold_clean", {28'd0, bus.clean_out}, 32'd0);
        check("reset_hold_busy",  {31'd0, bus.scan_busy_out}, 32'd0);
        bus.noisy_in = 4'h0;
        repeat (3) @(negedge clock_in);
        reset_n_in = 1'b1;

        // Step on channel 1
        align_after_scan();
        expect_pulse(4'b0010, 4'b0000, 4'b0010);
        bus.noisy_in = 4'b0010;
        wait_clean(4'b0010, 60, used);
        check("step_clean", {28'd0, bus.clean_out}, 32'h2);
        repeat (40) @(negedge clock_in);
        check("step_hold", {28'd0, bus.clean_out}, 32'h2);

        // Two-tick glitch on channel 2 must be rejected
        align_after_scan();
        bus.noisy_in[2] = 1'b1;
        repeat (16) @(negedge clock_in);
        bus.noisy_in[2] = 1'b0;
        repeat (40) @(negedge clock_in);
        check("glitch_clean", {28'd0, bus.clean_out}, 32'h2);

        // Disabled channel 0 ignores its input, then debounces once enabled
        align_after_scan();
        bus.enable_in[0] = 1'b0;
        bus.noisy_in[0]  = 1'b1;
        repeat (40) @(negedge clock_in);
        check("disabled_clean", {28'd0, bus.clean_out}, 32'h2);
        expect_pulse(4'b0001, 4'b0000, 4'b0011);
        bus.enable_in[0] = 1'b1;
        wait_clean(4'b0011, 60, used);
        check("enable_clean", {28'd0, bus.clean_out}, 32'h3);
        check("enable_latency", {31'd0, (used >= 17 && used <= 24)}, 32'd1);

        // Return to all-low, channel 0 falls before channel 1
        align_after_scan();
        expect_pulse(4'b0000, 4'b0001, 4'b0010);
        expect_pulse(4'b0000, 4'b0010, 4'b0000);
        bus.noisy_in = 4'h0;
        wait_clean(4'h0, 60, used);
        check("fall_clean", {28'd0, bus.clean_out}, 32'h0);

        // Concurrent rise: four consecutive slots in order 0..3
        align_after_scan();
        expect_pulse(4'b0001, 4'b0000, 4'b0001);
        expect_pulse(4'b0010, 4'b0000, 4'b0011);
        expect_pulse(4'b0100, 4'b0000, 4'b0111);
        expect_pulse(4'b1000, 4'b0000, 4'b1111);
        bus.noisy_in = 4'hF;
        used = 0;
        while (bus.clean_out === 4'h0 && used < 60) begin
            @(negedge clock_in);
            used++;
        end
        check("conc_slot0", {28'd0, bus.clean_out}, 32'h1);
        @(negedge clock_in);
        check("conc_slot1", {28'd0, bus.clean_out}, 32'h3);
        @(negedge clock_in);
        check("conc_slot2", {28'd0, bus.clean_out}, 32'h7);
        @(negedge clock_in);
        check("conc_slot3", {28'd0, bus.clean_out}, 32'hF);

        // Reset while a scan is in progress
        repeat (3) @(negedge clock_in);
        wait_busy(1'b1, 20);
        reset_n_in   = 1'b0;
        bus.noisy_in = 4'h0;
        #1;
        check("midrst_clean", {28'd0, bus.clean_out}, 32'h0);
        check("midrst_busy",  {31'd0, bus.scan_busy_out}, 32'd0);
        check("midrst_pulse", {24'd0, bus.rise_out, bus.fall_out}, 32'd0);
        repeat (3) @(negedge clock_in);
        reset_n_in = 1'b1;
        n = 0;
        while (bus.scan_busy_out !== 1'b1 && n < 40) begin
            @(negedge clock_in);
            n++;
        end
        check("first_scan_after_reset", n, 32'd8);

        repeat (30) @(negedge clock_in);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
